fastram_arbiter: RTL and testbench

Shares the single fast-RAM SDRAM port (fastram_address/datatoram/datafromram/we/ce) between two requesters: port A (CPU-side memory map) and port B (secondary master: HDD sector DMA or video fetch).
Sequences each access with a fixed read latency and a req/ack handshake.
Sits between the iigs core memory decode and the fastram pins of the top level.

---
 rtl/fastram_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_fastram_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fastram_arbiter.sv
// fastram_arbiter: shares the single fast-RAM SDRAM port between port A (CPU memory map)
// and port B (secondary master). One access at a time, fixed read latency, req/ack handshake.
// Optional statistics counters (a_count, b_count, conflict_count) are built when the macro
// FASTRAM_ARB_STATS_EN is defined.
module fastram_arbiter #(
    parameter int unsigned ADDR_W     = 23,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned B_PRIORITY = 0
) (
    input  logic              CLK_14M,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_wdata,
    output logic              a_ack,
    output logic [7:0]        a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_wdata,
    output logic              b_ack,
    output logic [7:0]        b_rdata,
    output logic [ADDR_W-1:0] fastram_address,
    output logic [7:0]        fastram_datatoram,
    input  logic [7:0]        fastram_datafromram,
    output logic              fastram_we,
    output logic              fastram_ce,
`ifdef FASTRAM_ARB_STATS_EN
    output logic [15:0]       a_count,
    output logic [15:0]       b_count,
    output logic [15:0]       conflict_count,
`endif
    output logic              busy
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    // WAIT is entered with the full latency so the capture edge lands RD_LATENCY clocks after ce
    localparam logic [2:0] LatInit = 3'(RD_LATENCY);

    logic [1:0]        state_q, state_d;
    logic              grant_b_q, grant_b_d;
    logic              last_b_q, last_b_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [7:0]        a_rdata_q, a_rdata_d;
    logic [7:0]        b_rdata_q, b_rdata_d;
    logic              both_req;
    logic              pick_b;

    // Arbitration: single requester wins outright; ties go by priority mode
    always_comb begin
        both_req = a_req & b_req;
        if (both_req) begin
            pick_b = (B_PRIORITY != 0) ? 1'b1 : ~last_b_q;
        end else begin
            pick_b = b_req;
        end
    end

    // Access sequencer next-state
    always_comb begin
        state_d   = state_q;
        grant_b_d = grant_b_q;
        last_b_d  = last_b_q;
        lat_cnt_d = lat_cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        case (state_q)
            StIdle: begin
                if (a_req || b_req) begin
                    grant_b_d = pick_b;
                    last_b_d  = pick_b;
                    addr_d    = pick_b ? b_addr  : a_addr;
                    wdata_d   = pick_b ? b_wdata : a_wdata;
                    we_d      = pick_b ? b_we    : a_we;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                if (we_q) begin
                    state_d = StDone;
                end else begin
                    lat_cnt_d = LatInit;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (lat_cnt_q == 3'd1) begin
                    if (grant_b_q) begin
                        b_rdata_d = fastram_datafromram;
                    end else begin
                        a_rdata_d = fastram_datafromram;
                    end
                    state_d = StDone;
                end else begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; last grant resets to B so A wins the first tie
    always_ff @(posedge CLK_14M or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            grant_b_q <= 1'b0;
            last_b_q  <= 1'b1;
            lat_cnt_q <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
            we_q      <= 1'b0;
            a_rdata_q <= 8'h00;
            b_rdata_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            grant_b_q <= grant_b_d;
            last_b_q  <= last_b_d;
            lat_cnt_q <= lat_cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Strobes decode straight from the state register so reset kills them immediately
    always_comb begin
        fastram_ce        = (state_q == StIssue);
        a_ack             = (state_q == StDone) & ~grant_b_q;
        b_ack             = (state_q == StDone) & grant_b_q;
        busy              = (state_q != StIdle);
        fastram_address   = addr_q;
        fastram_datatoram = wdata_q;
        fastram_we        = we_q;
        a_rdata           = a_rdata_q;
        b_rdata           = b_rdata_q;
    end

`ifdef FASTRAM_ARB_STATS_EN
    logic [15:0] a_cnt_q, b_cnt_q, conf_cnt_q;

    // Saturating access and conflict counters
    always_ff @(posedge CLK_14M or negedge reset_n) begin
        if (!reset_n) begin
            a_cnt_q    <= 16'h0000;
            b_cnt_q    <= 16'h0000;
            conf_cnt_q <= 16'h0000;
        end else begin
            if (a_ack && (a_cnt_q != 16'hFFFF)) begin
                a_cnt_q <= a_cnt_q + 16'h0001;
            end
            if (b_ack && (b_cnt_q != 16'hFFFF)) begin
                b_cnt_q <= b_cnt_q + 16'h0001;
            end
            if ((state_q == StIdle) && both_req && (conf_cnt_q != 16'hFFFF)) begin
                conf_cnt_q <= conf_cnt_q + 16'h0001;
            end
        end
    end

    // Counter outputs
    always_comb begin
        a_count        = a_cnt_q;
        b_count        = b_cnt_q;
        conflict_count = conf_cnt_q;
    end
`endif

endmodule

// File: tb/tb_fastram_arbiter.sv
// tb_fastram_arbiter: two arbiters (round-robin RD=2, B-priority RD=3) checked every clock
// against a transaction-level model; directed vector table plus hand sequences and random traffic.
module tb_fastram_arbiter;

    localparam int AW  = 23;
    localparam int RD0 = 2;
    localparam int RD1 = 3;

    logic          clk;
    logic          reset_n;
    logic          a_req[2], a_we[2], b_req[2], b_we[2];
    logic [AW-1:0] a_addr[2], b_addr[2], fa[2];
    logic [7:0]    a_wdata[2], b_wdata[2], a_rdata[2], b_rdata[2], fd[2], fdr[2];
    logic          a_ack[2], b_ack[2], fwe[2], fce[2], busy[2];
`ifdef FASTRAM_ARB_STATS_EN
    logic [15:0]   a_count[2], b_count[2], conflict_count[2];
`endif

    fastram_arbiter #(.ADDR_W(AW), .RD_LATENCY(RD0), .B_PRIORITY(0)) dut0 (
        .CLK_14M(clk), .reset_n(reset_n),
        .a_req(a_req[0]), .a_we(a_we[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
        .a_ack(a_ack[0]), .a_rdata(a_rdata[0]),
        .b_req(b_req[0]), .b_we(b_we[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
        .b_ack(b_ack[0]), .b_rdata(b_rdata[0]),
        .fastram_address(fa[0]), .fastram_datatoram(fd[0]), .fastram_datafromram(fdr[0]),
        .fastram_we(fwe[0]), .fastram_ce(fce[0]),
`ifdef FASTRAM_ARB_STATS_EN
        .a_count(a_count[0]), .b_count(b_count[0]), .conflict_count(conflict_count[0]),
`endif
        .busy(busy[0])
    );

    fastram_arbiter #(.ADDR_W(AW), .RD_LATENCY(RD1), .B_PRIORITY(1)) dut1 (
        .CLK_14M(clk), .reset_n(reset_n),
        .a_req(a_req[1]), .a_we(a_we[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
        .a_ack(a_ack[1]), .a_rdata(a_rdata[1]),
        .b_req(b_req[1]), .b_we(b_we[1]), .b_addr(b_addr[1]), .b_wdata(b_wdata[1]),
        .b_ack(b_ack[1]), .b_rdata(b_rdata[1]),
        .fastram_address(fa[1]), .fastram_datatoram(fd[1]), .fastram_datafromram(fdr[1]),
        .fastram_we(fwe[1]), .fastram_ce(fce[1]),
`ifdef FASTRAM_ARB_STATS_EN
        .a_count(a_count[1]), .b_count(b_count[1]), .conflict_count(conflict_count[1]),
`endif
        .busy(busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks, errors, cyc;

    // Transaction-level model: one access in flight, timed by arithmetic on cycle numbers
    bit            m_act[2], m_b[2], m_we[2], m_last_b[2];
    int            m_st[2], m_ack[2];
    logic [AW-1:0] m_addr[2], e_addr[2];
    logic [7:0]    m_wd[2], e_wd[2], e_ard[2], e_brd[2];
    logic          e_we[2];
    logic [7:0]    ref_mem[2][256];
    int unsigned   e_acnt[2], e_bcnt[2], e_ccnt[2];

    // Environment: SDRAM emulator and requesters
    logic [7:0]    emem[2][256];
    bit            ce_seen[2];
    int            ce_cyc[2];
    logic [7:0]    ce_idx[2];
    bit            seen_a[2], seen_b[2];
    int            ack_log[2][$];
    bit            auto_en[2];
    bit            chaos;
    int            a_prob[2], b_prob[2];

    typedef struct {
        logic          a_req, b_req;
        logic          x_ce, x_we;
        logic [AW-1:0] x_addr;
        logic [7:0]    x_wd;
        logic          x_aack, x_back, x_busy;
        logic [7:0]    x_ardata;
    } vec_t;
    vec_t tbl[9];

    function automatic int rd(input int k);
        return (k == 0) ? RD0 : RD1;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s inst%0d cyc %0d: got %0h want %0h", nm, k, cyc, got, want);
        end
    endtask

    task automatic req_step(input bit seen, input int prob, inout logic r, inout logic we,
                            inout logic [AW-1:0] ad, inout logic [7:0] wd);
        if (r && !seen) begin
            if (chaos && $urandom_range(0, 3) == 0) begin
                ad = AW'($urandom); ad[7:4] = 4'h0; wd = 8'($urandom); we = 1'($urandom);
            end
            if (chaos && $urandom_range(0, 15) == 0) r = 1'b0;
        end else if ($urandom_range(1, 100) <= prob) begin
            r = 1'b1; we = 1'($urandom); ad = AW'($urandom); ad[7:4] = 4'h0; wd = 8'($urandom);
        end else begin
            r = 1'b0;
        end
    endtask

    // Start of a clock: drive SDRAM read data and automatic requesters
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            fdr[k] = (ce_seen[k] && cyc == ce_cyc[k] + rd(k)) ? emem[k][ce_idx[k]] : 8'($urandom);
            if (auto_en[k]) begin
                req_step(seen_a[k], a_prob[k], a_req[k], a_we[k], a_addr[k], a_wdata[k]);
                req_step(seen_b[k], b_prob[k], b_req[k], b_we[k], b_addr[k], b_wdata[k]);
            end
        end
    endtask

    // Mid-clock: compare every output with the model, then advance the model
    task automatic sample();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            bit x_ce, x_aa, x_ba, x_busy, gb;
            if (!reset_n) begin
                m_act[k] = 0; m_last_b[k] = 1; e_addr[k] = '0; e_wd[k] = 0; e_we[k] = 0;
                e_ard[k] = 0; e_brd[k] = 0; e_acnt[k] = 0; e_bcnt[k] = 0; e_ccnt[k] = 0;
            end
            x_ce   = m_act[k] && cyc == m_st[k] + 1;
            x_aa   = m_act[k] && !m_b[k] && cyc == m_ack[k];
            x_ba   = m_act[k] && m_b[k] && cyc == m_ack[k];
            x_busy = m_act[k] && cyc > m_st[k];
            if (x_aa && !m_we[k]) e_ard[k] = ref_mem[k][m_addr[k][7:0]];
            if (x_ba && !m_we[k]) e_brd[k] = ref_mem[k][m_addr[k][7:0]];
            if (x_ce && m_we[k]) ref_mem[k][m_addr[k][7:0]] = m_wd[k];
            chk("ce", k, fce[k], x_ce);
            chk("we", k, fwe[k], e_we[k]);
            chk("addr", k, fa[k], e_addr[k]);
            chk("wdata", k, fd[k], e_wd[k]);
            chk("a_ack", k, a_ack[k], x_aa);
            chk("b_ack", k, b_ack[k], x_ba);
            chk("a_rdata", k, a_rdata[k], e_ard[k]);
            chk("b_rdata", k, b_rdata[k], e_brd[k]);
            chk("busy", k, busy[k], x_busy);
`ifdef FASTRAM_ARB_STATS_EN
            chk("a_count", k, a_count[k], e_acnt[k]);
            chk("b_count", k, b_count[k], e_bcnt[k]);
            chk("conflict_count", k, conflict_count[k], e_ccnt[k]);
`endif
            if (x_aa && e_acnt[k] < 32'hFFFF) e_acnt[k]++;
            if (x_ba && e_bcnt[k] < 32'hFFFF) e_bcnt[k]++;
            if (m_act[k] && cyc == m_ack[k]) begin
                m_act[k] = 0;
            end else if (!m_act[k] && reset_n && (a_req[k] || b_req[k])) begin
                if (a_req[k] && b_req[k]) begin
                    gb = (k == 1) ? 1'b1 : !m_last_b[k];
                    if (e_ccnt[k] < 32'hFFFF) e_ccnt[k]++;
                end else begin
                    gb = b_req[k];
                end
                m_act[k]    = 1;
                m_st[k]     = cyc;
                m_b[k]      = gb;
                m_last_b[k] = gb;
                m_we[k]     = gb ? b_we[k] : a_we[k];
                m_addr[k]   = gb ? b_addr[k] : a_addr[k];
                m_wd[k]     = gb ? b_wdata[k] : a_wdata[k];
                m_ack[k]    = cyc + (m_we[k] ? 2 : rd(k) + 2);
                e_addr[k]   = m_addr[k];
                e_wd[k]     = m_wd[k];
                e_we[k]     = m_we[k];
            end
            // environment bookkeeping from the pins
            seen_a[k] = a_ack[k];
            seen_b[k] = b_ack[k];
            if (a_ack[k]) ack_log[k].push_back(0);
            if (b_ack[k]) ack_log[k].push_back(1);
            if (fce[k] === 1'b1) begin
                ce_seen[k] = 1; ce_cyc[k] = cyc; ce_idx[k] = fa[k][7:0];
                if (fwe[k]) emem[k][fa[k][7:0]] = fd[k];
            end
        end
    endtask

    task automatic cycle();
        tick();
        sample();
    endtask

    task automatic do_reset();
        auto_en[0] = 0; auto_en[1] = 0; chaos = 0;
        for (int k = 0; k < 2; k++) begin a_req[k] = 0; b_req[k] = 0; end
        tick(); reset_n = 0; sample();
        cycle();
        tick(); reset_n = 1; sample();
    endtask

    task automatic serve(input int k, input bit pb, input bit we, input logic [AW-1:0] ad,
                         input logic [7:0] wd);
        int n;
        tick();
        if (pb) begin b_req[k] = 1; b_we[k] = we; b_addr[k] = ad; b_wdata[k] = wd; end
        else begin a_req[k] = 1; a_we[k] = we; a_addr[k] = ad; a_wdata[k] = wd; end
        sample();
        n = 0;
        while (!(pb ? seen_b[k] : seen_a[k]) && n < 40) begin cycle(); n++; end
        chk("serve_ack_seen", k, pb ? seen_b[k] : seen_a[k], 1);
        tick();
        if (pb) b_req[k] = 0; else a_req[k] = 0;
        sample();
    endtask

    initial begin
        int na, n;
        checks = 0; errors = 0; cyc = 0; chaos = 0;
        reset_n = 0;
        for (int k = 0; k < 2; k++) begin
            a_req[k] = 0; a_we[k] = 0; a_addr[k] = '0; a_wdata[k] = 0;
            b_req[k] = 0; b_we[k] = 0; b_addr[k] = '0; b_wdata[k] = 0; fdr[k] = 0;
            auto_en[k] = 0; a_prob[k] = 0; b_prob[k] = 0; m_last_b[k] = 1; m_act[k] = 0;
            ce_seen[k] = 0;
            for (int i = 0; i < 256; i++) begin
                ref_mem[k][i] = 8'(i * 7 + 3);
                emem[k][i]    = 8'(i * 7 + 3);
            end
        end
        ref_mem[0][8'h45] = 8'h5A;
        emem[0][8'h45]    = 8'h5A;

        // Reset state: model expects every output at zero
        repeat (3) cycle();
        tick(); reset_n = 1; sample();

        // Directed vectors: A read then B write on the round-robin instance
        tbl[0] = '{1, 0, 0, 0, 23'h000000, 8'h00, 0, 0, 0, 8'h00};
        tbl[1] = '{1, 0, 1, 0, 23'h012345, 8'h11, 0, 0, 1, 8'h00};
        tbl[2] = '{1, 0, 0, 0, 23'h012345, 8'h11, 0, 0, 1, 8'h00};
        tbl[3] = '{1, 0, 0, 0, 23'h012345, 8'h11, 0, 0, 1, 8'h00};
        tbl[4] = '{1, 0, 0, 0, 23'h012345, 8'h11, 1, 0, 1, 8'h5A};
        tbl[5] = '{0, 1, 0, 0, 23'h012345, 8'h11, 0, 0, 0, 8'h5A};
        tbl[6] = '{0, 1, 1, 1, 23'h7FFFFF, 8'hC3, 0, 0, 1, 8'h5A};
        tbl[7] = '{0, 1, 0, 1, 23'h7FFFFF, 8'hC3, 0, 1, 1, 8'h5A};
        tbl[8] = '{0, 0, 0, 1, 23'h7FFFFF, 8'hC3, 0, 0, 0, 8'h5A};
        for (int i = 0; i < 9; i++) begin
            tick();
            a_req[0] = tbl[i].a_req; a_we[0] = 0; a_addr[0] = 23'h012345; a_wdata[0] = 8'h11;
            b_req[0] = tbl[i].b_req; b_we[0] = 1; b_addr[0] = 23'h7FFFFF; b_wdata[0] = 8'hC3;
            sample();
            chk($sformatf("tbl%0d_ce", i), 0, fce[0], tbl[i].x_ce);
            chk($sformatf("tbl%0d_we", i), 0, fwe[0], tbl[i].x_we);
            chk($sformatf("tbl%0d_addr", i), 0, fa[0], tbl[i].x_addr);
            chk($sformatf("tbl%0d_wdata", i), 0, fd[0], tbl[i].x_wd);
            chk($sformatf("tbl%0d_a_ack", i), 0, a_ack[0], tbl[i].x_aack);
            chk($sformatf("tbl%0d_b_ack", i), 0, b_ack[0], tbl[i].x_back);
            chk($sformatf("tbl%0d_busy", i), 0, busy[0], tbl[i].x_busy);
            chk($sformatf("tbl%0d_a_rdata", i), 0, a_rdata[0], tbl[i].x_ardata);
        end

        // Continuous contention: inst0 alternates from A, inst1 always picks B
        do_reset();
        for (int k = 0; k < 2; k++) begin
            a_prob[k] = 100; b_prob[k] = 100; auto_en[k] = 1; ack_log[k].delete();
        end
        repeat (60) cycle();
        chk("rr_log_len", 0, (ack_log[0].size() >= 6), 1);
        foreach (ack_log[0][i]) chk($sformatf("rr_order%0d", i), 0, ack_log[0][i], i % 2);
        chk("bp_log_len", 1, (ack_log[1].size() >= 6), 1);
        foreach (ack_log[1][i]) chk($sformatf("bp_order%0d", i), 1, ack_log[1][i], 1);
        b_prob[1] = 0;
        repeat (10) cycle();
        ack_log[1].delete();
        repeat (30) cycle();
        na = 0;
        foreach (ack_log[1][i]) if (ack_log[1][i] == 0) na++;
        chk("bp_a_served_when_b_idle", 1, (na > 0), 1);

        // Reset during WAIT of an A read abandons it
        do_reset();
        tick(); a_req[0] = 1; a_we[0] = 0; a_addr[0] = 23'h000123; sample();
        cycle();
        cycle();
        chk("pre_rst_busy", 0, busy[0], 1);
        tick(); reset_n = 0; a_req[0] = 0;
        #1;
        chk("rst_ce", 0, fce[0], 0);
        chk("rst_a_ack", 0, a_ack[0], 0);
        chk("rst_busy", 0, busy[0], 0);
        sample();
        cycle();
        tick(); reset_n = 1; sample();
        ack_log[0].delete();
        repeat (8) cycle();
        chk("no_ack_after_abort", 0, ack_log[0].size(), 0);
        serve(0, 0, 0, 23'h012345, 8'h00);
        chk("post_rst_rdata", 0, a_rdata[0], 8'h5A);

`ifdef FASTRAM_ARB_STATS_EN
        // One conflict, then sequential accesses: 3 A, 2 B
        do_reset();
        tick();
        a_req[0] = 1; a_we[0] = 0; a_addr[0] = 23'h10; b_req[0] = 1; b_we[0] = 1;
        b_addr[0] = 23'h20; b_wdata[0] = 8'h77;
        sample();
        n = 0;
        while ((a_req[0] || b_req[0]) && n < 40) begin
            tick();
            if (seen_a[0]) a_req[0] = 0;
            if (seen_b[0]) b_req[0] = 0;
            sample();
            n++;
        end
        serve(0, 0, 1, 23'h31, 8'h01);
        serve(0, 0, 0, 23'h31, 8'h00);
        serve(0, 1, 0, 23'h20, 8'h00);
        chk("stats_a", 0, a_count[0], 3);
        chk("stats_b", 0, b_count[0], 2);
        chk("stats_conflict", 0, conflict_count[0], 1);
`endif

        // Random traffic with input wiggling after grant
        do_reset();
        chaos = 1;
        for (int k = 0; k < 2; k++) begin a_prob[k] = 40; b_prob[k] = 40; auto_en[k] = 1; end
        repeat (3000) cycle();
        chaos = 0;
        auto_en[0] = 0; auto_en[1] = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
